attack_sequencer: RTL
=====================

ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, attack ROM address width (1024 entries).
REQ-002 Parameter MAXIMUM_TIMES, default 30, game-time counter width.
REQ-003 Parameter SLOT_COUNT, default 4, number of attack-object slots.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begin pattern at base_addr.
REQ-007 abort  in  1  one-cycle pulse; stop pattern, return to IDLE.
REQ-008 base_addr  in  ADDR_WIDTH  first ROM entry of the pattern.
REQ-009 current_time  in  MAXIMUM_TIMES  game runtime counter.
REQ-010 rom_addr  out  ADDR_WIDTH  address driven to the attack object ROM reader.
REQ-011 fetch_req  out  1  one-cycle pulse; request ROM entry at rom_addr.
REQ-012 fetch_done  in  1  one-cycle pulse; ROM reader outputs valid.
REQ-013 next_attack_time  in  MAXIMUM_TIMES  launch time of the following entry, valid with fetch_done.
REQ-014 obj_type  in  5  type field of fetched entry; 0 = end-of-pattern marker.
REQ-015 slot_busy  in  SLOT_COUNT  per-slot occupied flag from position controllers.
REQ-016 slot_load  out  SLOT_COUNT  one-hot one-cycle pulse; slot i latches ROM outputs.
REQ-017 busy  out  1  high in any state except IDLE and DONE.
REQ-018 pattern_done  out  1  level, high in DONE.
REQ-019 drop_err  out  1  sticky; an object was dropped for lack of a slot.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT_DATA, WAIT_SLOT, DISPATCH, WAIT_TIME, DONE.
REQ-021 IDLE/DONE: start -> rom_addr <= base_addr, drop_err <= 0, go FETCH next cycle.
REQ-022 FETCH: fetch_req = 1 for exactly one cycle, then WAIT_DATA.
REQ-023 WAIT_DATA: on fetch_done latch next_attack_time and obj_type; obj_type == 0 -> DONE, else WAIT_SLOT.
REQ-024 WAIT_SLOT: if any slot_busy bit is 0, select the lowest free index and go DISPATCH; else increment 8-bit stall counter.
REQ-025 Stall counter reaching 255 SHALL set drop_err, discard the object, advance rom_addr, go WAIT_TIME.
REQ-026 DISPATCH: slot_load = one-hot of selected slot for one cycle; rom_addr <= rom_addr + 1; go WAIT_TIME.
REQ-027 rom_addr increment from all-ones SHALL go DONE instead of WAIT_TIME (no wrap-around replay).
REQ-028 WAIT_TIME: unsigned compare current_time >= latched time -> FETCH; equal counts as reached.
REQ-029 Latency: start to fetch_req = 1 cycle; fetch_done to slot_load = 2 cycles when a slot is free.
REQ-030 abort SHALL force IDLE next cycle from any state, suppressing fetch_req and slot_load that cycle.
REQ-031 start outside IDLE/DONE SHALL be ignored; start and abort together: abort wins.
REQ-032 fetch_done outside WAIT_DATA SHALL be ignored.
REQ-033 slot_load and fetch_req SHALL never assert in the same cycle.

Reset
REQ-034 reset SHALL override abort/start: state IDLE, rom_addr 0, fetch_req 0, slot_load 0, busy 0, pattern_done 0, drop_err 0, stall counter 0, latched time/type 0.
REQ-035 reset mid-operation SHALL discard any outstanding fetch; a late fetch_done is ignored per REQ-032.

Structure
REQ-036 State encoding, ROM field widths and the end-marker value SHALL live in a shared package used by ROM reader and sequencer.
REQ-037 The lowest-free-slot priority encoder SHALL be one sub-module, slot_allocator (slot_busy in; one-hot grant and any_free out).

Verification
REQ-038 start, base_addr=5, entry 5 type 3, next time 40, slots free -> fetch_req at cycle 1, slot_load=0001 2 cycles after fetch_done, rom_addr=6, fetch waits until current_time=40.
REQ-039 slot_busy=1011 at dispatch -> slot_load=0100.
REQ-040 slot_busy=1111 held 255 cycles -> drop_err=1, no slot_load, rom_addr advanced.
REQ-041 entry with obj_type=0 -> DONE, pattern_done=1, busy=0; new start restarts and clears drop_err.
REQ-042 abort during WAIT_SLOT -> IDLE next cycle, no slot_load; reset during WAIT_DATA then fetch_done -> no state change.
REQ-043 base_addr=1023 entry dispatched -> DONE, no fetch at address 0.

Source files
------------

// File: rtl/attack_sequencer_pkg.sv
// attack_sequencer_pkg
// Shared definitions for the attack-pattern sequencer and the attack object
// ROM reader: sequencer state encoding, ROM entry field widths, the
// end-of-pattern marker value and the slot stall limit.
package attack_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_SLOT = 3'd3,
    S_DISPATCH  = 3'd4,
    S_WAIT_TIME = 3'd5,
    S_DONE      = 3'd6
  } seq_state_t;

  // ROM entry type field
  localparam int OBJ_TYPE_W = 5;
  localparam logic [OBJ_TYPE_W-1:0] OBJ_END_MARKER = 5'd0;

  // Stall counter: the object is dropped on the cycle the counter would
  // reach 255, i.e. after 255 consecutive cycles with every slot busy.
  localparam int STALL_W = 8;
  localparam logic [STALL_W-1:0] STALL_LAST = 8'd254;

  // True when a fetched type field marks the end of the pattern
  function automatic logic is_end_marker(input logic [OBJ_TYPE_W-1:0] obj_type);
    return (obj_type == OBJ_END_MARKER);
  endfunction

endpackage

// File: rtl/attack_sequencer_slot_allocator.sv
// slot_allocator
// Lowest-index-first priority encoder over the attack-object slots.
// Ports:
//   i_slot_busy  per-slot occupied flags
//   o_grant      one-hot grant of the lowest free slot (zero when none free)
//   o_any_free   at least one slot is free
module slot_allocator #(
  parameter int SLOT_COUNT = 4
) (
  input  logic [SLOT_COUNT-1:0] i_slot_busy,
  output logic [SLOT_COUNT-1:0] o_grant,
  output logic                  o_any_free
);

  logic w_found;

  // Scan upward; the first free slot wins and blocks all higher ones
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (!i_slot_busy[i] && !w_found) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end else begin
        o_grant[i] = o_grant[i];
      end
    end
    o_any_free = w_found;
  end

endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer
// Walks an attack pattern stored in the attack object ROM: fetches one entry
// at a time, hands it to the lowest free attack-object slot, then waits for
// the game clock to reach the launch time of the following entry.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start, i_abort        pattern control pulses (abort wins)
//   i_base_addr             first ROM entry of the pattern
//   i_current_time          game runtime counter
//   o_rom_addr, o_fetch_req ROM reader request
//   i_fetch_done, i_next_attack_time, i_obj_type   ROM reader response
//   i_slot_busy, o_slot_load  slot occupancy / one-hot load pulse
//   o_busy, o_pattern_done, o_drop_err  status
module attack_sequencer
  import attack_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int SLOT_COUNT    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [MAXIMUM_TIMES-1:0] i_current_time,
  output logic [ADDR_WIDTH-1:0]    o_rom_addr,
  output logic                     o_fetch_req,
  input  logic                     i_fetch_done,
  input  logic [MAXIMUM_TIMES-1:0] i_next_attack_time,
  input  logic [OBJ_TYPE_W-1:0]    i_obj_type,
  input  logic [SLOT_COUNT-1:0]    i_slot_busy,
  output logic [SLOT_COUNT-1:0]    o_slot_load,
  output logic                     o_busy,
  output logic                     o_pattern_done,
  output logic                     o_drop_err
);

  seq_state_t                r_state;
  seq_state_t                w_next_state;
  logic [ADDR_WIDTH-1:0]     r_rom_addr;
  logic                      r_drop_err;
  logic [STALL_W-1:0]        r_stall;
  logic [MAXIMUM_TIMES-1:0]  r_time;
  logic [OBJ_TYPE_W-1:0]     r_type;
  logic [SLOT_COUNT-1:0]     r_grant;

  logic [SLOT_COUNT-1:0]     w_grant;
  logic                      w_any_free;
  logic                      w_addr_last;
  logic                      w_load_base;
  logic                      w_adv_addr;
  logic                      w_latch;
  logic                      w_set_drop;
  logic                      w_stall_inc;
  logic                      w_stall_clr;
  logic                      w_take_grant;

  slot_allocator #(
    .SLOT_COUNT (SLOT_COUNT)
  ) u_slot_allocator (
    .i_slot_busy (i_slot_busy),
    .o_grant     (w_grant),
    .o_any_free  (w_any_free)
  );

  // Incrementing from all-ones would replay the pattern from address 0
  assign w_addr_last = &r_rom_addr;

  // Next-state and datapath control decode; abort overrides every state
  always_comb begin
    w_next_state = r_state;
    w_load_base  = 1'b0;
    w_adv_addr   = 1'b0;
    w_latch      = 1'b0;
    w_set_drop   = 1'b0;
    w_stall_inc  = 1'b0;
    w_stall_clr  = 1'b0;
    w_take_grant = 1'b0;
    if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_load_base  = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = r_state;
          end
        end
        S_FETCH: begin
          w_next_state = S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (i_fetch_done) begin
            w_latch     = 1'b1;
            w_stall_clr = 1'b1;
            if (is_end_marker(i_obj_type)) begin
              w_next_state = S_DONE;
            end else begin
              w_next_state = S_WAIT_SLOT;
            end
          end else begin
            w_next_state = S_WAIT_DATA;
          end
        end
        S_WAIT_SLOT: begin
          if (is_end_marker(r_type)) begin
            // Defensive: an end marker must never be dispatched
            w_next_state = S_DONE;
          end else if (w_any_free) begin
            w_take_grant = 1'b1;
            w_stall_clr  = 1'b1;
            w_next_state = S_DISPATCH;
          end else if (r_stall == STALL_LAST) begin
            w_set_drop   = 1'b1;
            w_stall_clr  = 1'b1;
            w_adv_addr   = 1'b1;
            w_next_state = w_addr_last ? S_DONE : S_WAIT_TIME;
          end else begin
            w_stall_inc  = 1'b1;
            w_next_state = S_WAIT_SLOT;
          end
        end
        S_DISPATCH: begin
          w_adv_addr   = 1'b1;
          w_next_state = w_addr_last ? S_DONE : S_WAIT_TIME;
        end
        S_WAIT_TIME: begin
          if (i_current_time >= r_time) begin
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WAIT_TIME;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register and sequencer datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_drop_err <= 1'b0;
      r_stall    <= '0;
      r_time     <= '0;
      r_type     <= '0;
      r_grant    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_base) begin
        r_rom_addr <= i_base_addr;
      end else if (w_adv_addr) begin
        r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
      end else begin
        r_rom_addr <= r_rom_addr;
      end
      if (w_load_base) begin
        r_drop_err <= 1'b0;
      end else if (w_set_drop) begin
        r_drop_err <= 1'b1;
      end else begin
        r_drop_err <= r_drop_err;
      end
      if (w_stall_clr) begin
        r_stall <= '0;
      end else if (w_stall_inc) begin
        r_stall <= r_stall + 8'd1;
      end else begin
        r_stall <= r_stall;
      end
      if (w_latch) begin
        r_time <= i_next_attack_time;
        r_type <= i_obj_type;
      end else begin
        r_time <= r_time;
        r_type <= r_type;
      end
      if (w_take_grant) begin
        r_grant <= w_grant;
      end else begin
        r_grant <= r_grant;
      end
    end
  end

  // Request pulses are state-decoded; abort squelches them in its own cycle.
  // FETCH and DISPATCH are distinct states, so the two never coincide.
  assign o_fetch_req    = (r_state == S_FETCH) && !i_abort;
  assign o_slot_load    = ((r_state == S_DISPATCH) && !i_abort) ? r_grant : '0;
  assign o_rom_addr     = r_rom_addr;
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_pattern_done = (r_state == S_DONE);
  assign o_drop_err     = r_drop_err;

endmodule
